// File: rtl/pe_param.sv
// pe_param: multiply-accumulate PE with operand FIFOs, operand forwarding and saturating result.
// Optional round-half-away-from-zero before the output shift: define PE_PARAM_ROUND_EN.
module pe_param #(
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int FDEPTH = 4,
  parameter int SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  input  logic                 a_we,
  input  logic                 b_we,
  output logic                 a_ff,
  output logic                 b_ff,
  input  logic                 start,
  input  logic [7:0]           max_cntr,
  output logic                 start_next,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic                 a_vld,
  output logic                 b_vld,
  output logic signed [DW-1:0] s_out,
  output logic                 s_vld,
  input  logic                 s_rdy,
  output logic                 sat
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] HALF   = (ONE << SHIFT) >> 1;
  localparam logic [AW-1:0] HALF_M = (SHIFT == 0) ? {AW{1'b0}} : (HALF - ONE);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0]   r_mem [2][FDEPTH];
  logic [PW-1:0]          r_wp [2];
  logic [PW-1:0]          r_rp [2];
  logic [CW-1:0]          r_cnt [2];
  logic [1:0]             r_ff;
  logic [CW-1:0]          w_cnt_nxt [2];
  logic [1:0]             w_wr;
  logic [1:0]             w_ne;
  logic                   w_en;
  logic                   w_pop;

  logic signed [DW-1:0]   r_a_out, r_b_out, r_s_out;
  logic                   r_fwd_vld, r_v1, r_v2, r_v3, r_s_vld, r_sat, r_start_next;
  logic signed [2*DW-1:0] r_prod;
  logic signed [AW-1:0]   r_acc, r_res;
  logic [7:0]             r_pcnt;

  logic signed [AW-1:0]   w_prod_ext, w_sum, w_bias, w_rnd, w_sh;
  logic signed [DW-1:0]   w_clip;
  logic                   w_last, w_clipped;

  // Pipeline enable, pop decision and FIFO occupancy bookkeeping.
  always_comb begin
    w_en  = ~(r_s_vld & ~s_rdy);
    w_ne  = 2'b00;
    for (int k = 0; k < 2; k++) begin
      w_ne[k] = (r_cnt[k] != {CW{1'b0}});
    end
    w_pop   = w_ne[0] & w_ne[1] & w_en & ~start;
    w_wr[0] = a_we & (~r_ff[0] | w_pop);
    w_wr[1] = b_we & (~r_ff[1] | w_pop);
    for (int k = 0; k < 2; k++) begin
      w_cnt_nxt[k] = r_cnt[k] + {{(CW-1){1'b0}}, w_wr[k]} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_wr[0]) r_mem[0][r_wp[0]] <= a_in;
    if (w_wr[1]) r_mem[1][r_wp[1]] <= b_in;
  end

  // FIFO pointers, occupancy and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_wp[k]  <= {PW{1'b0}};
        r_rp[k]  <= {PW{1'b0}};
        r_cnt[k] <= {CW{1'b0}};
      end
      r_ff <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_wr[k]) r_wp[k] <= r_wp[k] + {{(PW-1){1'b0}}, 1'b1};
        if (w_pop)   r_rp[k] <= r_rp[k] + {{(PW-1){1'b0}}, 1'b1};
        r_cnt[k] <= w_cnt_nxt[k];
        r_ff[k]  <= (w_cnt_nxt[k] == CW'(FDEPTH));
      end
    end
  end

  // Accumulate, pick the output rounding bias, shift and clip.
  always_comb begin
    w_prod_ext = {{(AW-2*DW){r_prod[2*DW-1]}}, r_prod};
    w_sum      = r_acc + w_prod_ext;
    w_last     = (r_pcnt == max_cntr);
`ifdef PE_PARAM_ROUND_EN
    w_bias = r_res[AW-1] ? $signed(HALF_M) : $signed(HALF);
`else
    w_bias = {AW{1'b0}};
`endif
    w_rnd = r_res + w_bias;
    w_sh  = w_rnd >>> SHIFT;
    if (w_sh > MAXV) begin
      w_clip    = {1'b0, {(DW-1){1'b1}}};
      w_clipped = 1'b1;
    end else if (w_sh < MINV) begin
      w_clip    = {1'b1, {(DW-1){1'b0}}};
      w_clipped = 1'b1;
    end else begin
      w_clip    = w_sh[DW-1:0];
      w_clipped = 1'b0;
    end
  end

  // Datapath: forward stage, product stage, accumulate stage, result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_out <= {DW{1'b0}};
      r_b_out <= {DW{1'b0}};
      r_fwd_vld <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_prod <= {(2*DW){1'b0}};
      r_acc <= {AW{1'b0}};
      r_res <= {AW{1'b0}};
      r_pcnt <= 8'd0;
      r_s_out <= {DW{1'b0}};
      r_s_vld <= 1'b0;
      r_sat <= 1'b0;
      r_start_next <= 1'b0;
    end else begin
      r_start_next <= start;
      r_fwd_vld    <= w_pop;
      if (w_pop) begin
        r_a_out <= r_mem[0][r_rp[0]];
        r_b_out <= r_mem[1][r_rp[1]];
      end
      if (start) begin
        // A pending result survives start; a completing one is discarded.
        r_v1    <= 1'b0;
        r_v2    <= 1'b0;
        r_v3    <= 1'b0;
        r_acc   <= {AW{1'b0}};
        r_pcnt  <= 8'd0;
        r_sat   <= 1'b0;
        r_s_vld <= r_s_vld & ~s_rdy;
      end else if (w_en) begin
        r_v1   <= w_pop;
        r_v2   <= r_v1;
        r_prod <= r_a_out * r_b_out;
        r_v3   <= r_v2 & w_last;
        if (r_v2) begin
          if (w_last) begin
            r_res  <= w_sum;
            r_acc  <= {AW{1'b0}};
            r_pcnt <= 8'd0;
          end else begin
            r_acc  <= w_sum;
            r_pcnt <= r_pcnt + 8'd1;
          end
        end
        r_s_vld <= r_v3;
        if (r_v3) begin
          r_s_out <= w_clip;
          if (w_clipped) r_sat <= 1'b1;
        end
      end
    end
  end

  assign a_ff       = r_ff[0];
  assign b_ff       = r_ff[1];
  assign a_out      = r_a_out;
  assign b_out      = r_b_out;
  assign a_vld      = r_fwd_vld;
  assign b_vld      = r_fwd_vld;
  assign s_out      = r_s_out;
  assign s_vld      = r_s_vld;
  assign sat        = r_sat;
  assign start_next = r_start_next;

endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: default instance (SHIFT=0) plus a SHIFT=2 instance for the output shift.
module tb_pe_param;

  logic clk, rst_n;
  logic signed [15:0] a_in, b_in, a_out, b_out, s_out;
  logic a_we, b_we, a_ff, b_ff, start, start_next, a_vld, b_vld, s_vld, s_rdy, sat;
  logic [7:0] max_cntr;

  logic signed [15:0] s2_a_in, s2_b_in, s2_a_out, s2_b_out, s2_out;
  logic s2_a_we, s2_b_we, s2_a_ff, s2_b_ff, s2_start, s2_start_next;
  logic s2_a_vld, s2_b_vld, s2_vld, s2_rdy, s2_sat;
  logic [7:0] s2_max;

  int errs = 0;
  int checks = 0;
  logic signed [15:0] res_q[$], fwd_q[$], res2_q[$];

  pe_param u_dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .a_we(a_we), .b_we(b_we),
    .a_ff(a_ff), .b_ff(b_ff), .start(start), .max_cntr(max_cntr), .start_next(start_next),
    .a_out(a_out), .b_out(b_out), .a_vld(a_vld), .b_vld(b_vld),
    .s_out(s_out), .s_vld(s_vld), .s_rdy(s_rdy), .sat(sat)
  );

  pe_param #(.SHIFT(2)) u_sh (
    .clk(clk), .rst_n(rst_n), .a_in(s2_a_in), .b_in(s2_b_in), .a_we(s2_a_we), .b_we(s2_b_we),
    .a_ff(s2_a_ff), .b_ff(s2_b_ff), .start(s2_start), .max_cntr(s2_max), .start_next(s2_start_next),
    .a_out(s2_a_out), .b_out(s2_b_out), .a_vld(s2_a_vld), .b_vld(s2_b_vld),
    .s_out(s2_out), .s_vld(s2_vld), .s_rdy(s2_rdy), .sat(s2_sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_vld && s_rdy) res_q.push_back(s_out);
    if (a_vld) fwd_q.push_back(a_out);
    if (s2_vld && s2_rdy) res2_q.push_back(s2_out);
  end

  task automatic write_pair(input logic signed [15:0] a, input logic signed [15:0] b);
    a_in = a; b_in = b; a_we = 1'b1; b_we = 1'b1;
    @(posedge clk); #1;
    a_we = 1'b0; b_we = 1'b0;
  endtask

  task automatic write_pair2(input logic signed [15:0] a, input logic signed [15:0] b);
    s2_a_in = a; s2_b_in = b; s2_a_we = 1'b1; s2_b_we = 1'b1;
    @(posedge clk); #1;
    s2_a_we = 1'b0; s2_b_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({a_out, b_out, s_out} !== 48'd0) begin
      errs++; $display("FAIL reset_data: got %h %h %h want 0", a_out, b_out, s_out);
    end
    checks++;
    if ({a_vld, b_vld, s_vld, sat, start_next, a_ff, b_ff} !== 7'd0) begin
      errs++; $display("FAIL reset_flags: got %b want 0000000", {a_vld, b_vld, s_vld, sat, start_next, a_ff, b_ff});
    end
  endtask

  task automatic test_basic;
    res_q.delete(); fwd_q.delete();
    max_cntr = 8'd3; s_rdy = 1'b1;
    write_pair(16'sd1, 16'sd5); write_pair(16'sd2, 16'sd6);
    write_pair(16'sd3, 16'sd7); write_pair(16'sd4, 16'sd8);
    idle(20);
    checks++;
    if (res_q.size() !== 1) begin
      errs++; $display("FAIL basic_count: got %0d results want 1", res_q.size());
    end else begin
      checks++;
      if (res_q[0] !== 16'sd70) begin
        errs++; $display("FAIL basic_sum: got %0d want 70", res_q[0]);
      end
    end
    checks++;
    if (fwd_q.size() !== 4) begin
      errs++; $display("FAIL basic_fwd_count: got %0d want 4", fwd_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fwd_q[i] !== 16'(i + 1)) begin
          errs++; $display("FAIL basic_fwd[%0d]: got %0d want %0d", i, fwd_q[i], i + 1);
        end
      end
    end
    checks++;
    if (sat !== 1'b0) begin
      errs++; $display("FAIL basic_sat: got %b want 0", sat);
    end
  endtask

  task automatic test_saturation;
    res_q.delete();
    max_cntr = 8'd1;
    write_pair(16'sd32767, 16'sd32767); write_pair(16'sd32767, 16'sd32767);
    idle(15);
    checks++;
    if (res_q.size() !== 1 || res_q[0] !== 16'sd32767) begin
      errs++; $display("FAIL sat_value: got %0d results, first %0d want 1 result 32767", res_q.size(), (res_q.size() > 0) ? res_q[0] : 16'sd0);
    end
    checks++;
    if (sat !== 1'b1) begin
      errs++; $display("FAIL sat_flag: got %b want 1", sat);
    end
    pulse_start;
    checks++;
    if (sat !== 1'b0 || start_next !== 1'b1) begin
      errs++; $display("FAIL sat_clear: got sat=%b start_next=%b want 0 1", sat, start_next);
    end
    idle(1);
    checks++;
    if (start_next !== 1'b0) begin
      errs++; $display("FAIL start_next_pulse: got %b want 0", start_next);
    end
  endtask

  task automatic test_backpressure;
    logic signed [15:0] exp_v [5];
    exp_v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};
    res_q.delete(); fwd_q.delete();
    max_cntr = 8'd0; s_rdy = 1'b0;
    write_pair(16'sd1, 16'sd1);
    for (int i = 0; i < 20; i++) begin
      if (s_vld) break;
      @(posedge clk); #1;
    end
    checks++;
    if (s_vld !== 1'b1 || s_out !== 16'sd1) begin
      errs++; $display("FAIL bp_pending: got vld=%b out=%0d want 1 1", s_vld, s_out);
    end
    for (int i = 2; i <= 5; i++) write_pair(16'(i), 16'sd1);
    checks++;
    if (a_ff !== 1'b1 || b_ff !== 1'b1) begin
      errs++; $display("FAIL bp_full: got a_ff=%b b_ff=%b want 1 1", a_ff, b_ff);
    end
    write_pair(16'sd6, 16'sd1);
    idle(3);
    checks++;
    if (fwd_q.size() !== 1 || s_out !== 16'sd1 || a_ff !== 1'b1) begin
      errs++; $display("FAIL bp_hold: got pops=%0d out=%0d ff=%b want 1 1 1", fwd_q.size(), s_out, a_ff);
    end
    s_rdy = 1'b1;
    idle(30);
    checks++;
    if (res_q.size() !== 5) begin
      errs++; $display("FAIL bp_count: got %0d results want 5", res_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (res_q[i] !== exp_v[i]) begin
          errs++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, res_q[i], exp_v[i]);
        end
      end
    end
    checks++;
    if (a_ff !== 1'b0 || s_vld !== 1'b0) begin
      errs++; $display("FAIL bp_drain: got ff=%b vld=%b want 0 0", a_ff, s_vld);
    end
  endtask

  task automatic test_shift;
    logic signed [15:0] exp_pos;
`ifdef PE_PARAM_ROUND_EN
    exp_pos = 16'sd2;
`else
    exp_pos = 16'sd1;
`endif
    res2_q.delete();
    write_pair2(16'sd3, 16'sd2);
    write_pair2(-16'sd3, 16'sd2);
    idle(15);
    checks++;
    if (res2_q.size() !== 2) begin
      errs++; $display("FAIL shift_count: got %0d want 2", res2_q.size());
    end else begin
      checks++;
      if (res2_q[0] !== exp_pos) begin
        errs++; $display("FAIL shift_pos: got %0d want %0d", res2_q[0], exp_pos);
      end
      checks++;
      if (res2_q[1] !== -16'sd2) begin
        errs++; $display("FAIL shift_neg: got %0d want -2", res2_q[1]);
      end
    end
  endtask

  task automatic test_start_mid;
    res_q.delete();
    max_cntr = 8'd3; s_rdy = 1'b1;
    write_pair(16'sd10, 16'sd10); write_pair(16'sd20, 16'sd20);
    idle(8);
    pulse_start;
    write_pair(16'sd1, 16'sd1); write_pair(16'sd2, 16'sd2);
    write_pair(16'sd3, 16'sd3); write_pair(16'sd4, 16'sd4);
    idle(20);
    checks++;
    if (res_q.size() !== 1 || res_q[0] !== 16'sd30) begin
      errs++; $display("FAIL start_mid: got %0d results, first %0d want 1 result 30", res_q.size(), (res_q.size() > 0) ? res_q[0] : 16'sd0);
    end
  endtask

  task automatic test_reset_mid;
    res_q.delete();
    write_pair(16'sd5, 16'sd5); write_pair(16'sd6, 16'sd6);
    idle(1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out, b_out, s_out} !== 48'd0 || {a_vld, b_vld, s_vld, sat, a_ff, b_ff} !== 6'd0) begin
      errs++; $display("FAIL rst_mid_outputs: got %h %h %h flags %b want all 0", a_out, b_out, s_out, {a_vld, b_vld, s_vld, sat, a_ff, b_ff});
    end
    idle(2);
    rst_n = 1'b1;
    fwd_q.delete();
    idle(10);
    checks++;
    if (res_q.size() !== 0 || fwd_q.size() !== 0) begin
      errs++; $display("FAIL rst_mid_spurious: got %0d results %0d pops want 0 0", res_q.size(), fwd_q.size());
    end
    write_pair(16'sd1, 16'sd2); write_pair(16'sd1, 16'sd2);
    idle(10);
    checks++;
    if (res_q.size() !== 0) begin
      errs++; $display("FAIL rst_mid_partial: got %0d results want 0", res_q.size());
    end
    write_pair(16'sd2, 16'sd3); write_pair(16'sd2, 16'sd3);
    idle(15);
    checks++;
    if (res_q.size() !== 1 || res_q[0] !== 16'sd16) begin
      errs++; $display("FAIL rst_mid_group: got %0d results, first %0d want 1 result 16", res_q.size(), (res_q.size() > 0) ? res_q[0] : 16'sd0);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    a_in = 16'sd0; b_in = 16'sd0; a_we = 1'b0; b_we = 1'b0;
    start = 1'b0; max_cntr = 8'd0; s_rdy = 1'b1;
    s2_a_in = 16'sd0; s2_b_in = 16'sd0; s2_a_we = 1'b0; s2_b_we = 1'b0;
    s2_start = 1'b0; s2_max = 8'd0; s2_rdy = 1'b1;
    idle(3);
    test_reset;
    rst_n = 1'b1;
    idle(2);
    test_basic;
    test_saturation;
    test_backpressure;
    test_shift;
    test_start_mid;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
